// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op-codes, FSM encoding and counter sizing.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int XLEN_DEFAULT = 32;

  // Counter must hold the value XLEN itself, hence the extra bit.
  function automatic int cnt_width(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

  localparam int CNT_W = cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes/sign flags at accept,
// special-case division results, and final conditional negation.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            sign_a,
  output logic            sign_b,
  output logic            special,
  output logic [XLEN-1:0] special_res,
  input  logic [2:0]      op_q,
  input  logic            sign_a_q,
  input  logic            sign_b_q,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] final_res
);

  logic            a_signed, b_signed, b_zero, ovf;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    sign_a   = a_signed & op_a[XLEN-1];
    sign_b   = b_signed & op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;

    b_zero  = (op_b == '0);
    ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
              (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special = funct3[2] && (b_zero || ovf);
    // funct3[1] distinguishes remainder from quotient among the divides
    if (b_zero) special_res = funct3[1] ? op_a : '1;
    else        special_res = funct3[1] ? '0   : op_a;
  end

  always_comb begin
    prod     = {hi, lo};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -lo : lo;
    rem_fix  = sign_a_q ? -hi : hi;
    final_res = '0;
    case (op_q)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = quo_fix;
      default:                      final_res = rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, stalling the core through busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);

  localparam int CW = cnt_width(XLEN);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            sign_a_q, sign_b_q;
  // {acc, shreg} is the 2*XLEN product for multiply; for divide acc is the
  // partial remainder and shreg shifts dividend bits out / quotient bits in.
  logic [XLEN-1:0] acc, shreg, opnd;

  logic [XLEN-1:0] mag_a, mag_b, special_res, final_res;
  logic            sign_a, sign_b, special, accept;
  logic [XLEN:0]   mul_sum, div_trial;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .funct3      (funct3),
    .op_a        (op_a),
    .op_b        (op_b),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .sign_a      (sign_a),
    .sign_b      (sign_b),
    .special     (special),
    .special_res (special_res),
    .op_q        (op_q),
    .sign_a_q    (sign_a_q),
    .sign_b_q    (sign_b_q),
    .hi          (acc),
    .lo          (shreg),
    .final_res   (final_res)
  );

  assign accept    = (state == ST_IDLE) && start;
  assign mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
  assign div_trial = {acc, shreg[XLEN-1]} - {1'b0, opnd};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      result   <= '0;
      rd_out   <= '0;
    end else if (accept) begin
      op_q     <= funct3;
      rd_q     <= rd_in;
      sign_a_q <= sign_a;
      sign_b_q <= sign_b;
      acc      <= '0;
      cnt      <= CW'(XLEN);
      if (funct3[2]) begin
        shreg <= mag_a;
        opnd  <= mag_b;
      end else begin
        shreg <= mag_b;
        opnd  <= mag_a;
      end
      if (special) begin
        result <= special_res;
        rd_out <= rd_in;
      end
    end else if (state == ST_CALC) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (op_q[2]) begin
          // Top bit of the trial difference is the borrow: set means no fit
          if (!div_trial[XLEN]) begin
            acc   <= div_trial[XLEN-1:0];
            shreg <= {shreg[XLEN-2:0], 1'b1};
          end else begin
            acc   <= {acc[XLEN-2:0], shreg[XLEN-1]};
            shreg <= {shreg[XLEN-2:0], 1'b0};
          end
        end else begin
          acc   <= mul_sum[XLEN:1];
          shreg <= {mul_sum[0], shreg[XLEN-1:1]};
        end
      end else begin
        result <= final_res;
        rd_out <= rd_q;
      end
    end
  end

  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign wb_en = done && (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit with a queue scoreboard and
// an independent 64-bit reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wb;
    int          lat;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    case (f)
      3'b000: begin p = sa * sbv; return p[31:0]; end
      3'b001: begin p = sa * sbv; return p[63:32]; end
      3'b010: begin p = sa * ub;  return p[63:32]; end
      3'b011: begin p = ua * ub;  return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(int'(a) / int'(b));
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(int'(a) % int'(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one op, wait for done (bounded), check against the scoreboard.
  // glitch pulses extra starts while busy and holds start through DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input bit glitch);
    exp_t e, got;
    int   edges;
    bit   busy_ok;
    e.res = exp_res;
    e.rd  = rd;
    e.wb  = (rd != 0);
    e.lat = is_fast(f, a, b) ? 0 : 33;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; rd_in = 5'd17;
    edges = 0;
    busy_ok = 1'b1;
    while (!done && edges < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (glitch && (edges == 5 || edges == 6)) begin
        start = 1'b1; funct3 = F3_DIVU; op_a = 32'd1000; op_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = glitch;
    got = sb.pop_front();
    chk("done_seen", done, 1);
    chk("latency", edges, got.lat);
    chk("busy_held", busy_ok, 1);
    chk("result", result, got.res);
    chk("rd_out", rd_out, got.rd);
    chk("wb_en", wb_en, got.wb);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    bit saw_done;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_result", result, 0);
    chk("rst_rd_out", rd_out, 0);
    reset = 1'b0;

    run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 0);
    run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0);
    run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 0);
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4, 32'hFFFF_FFFD, 0);
    run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd6, 32'hFFFF_FFFF, 0);
    run_op(F3_DIVU,   32'd100,        32'd7,         5'd7, 32'd14,        0);
    run_op(F3_REMU,   32'd100,        32'd7,         5'd8, 32'd2,         0);
    run_op(F3_DIV,    32'd5,          32'd0,         5'd9, 32'hFFFF_FFFF, 0);
    run_op(F3_REM,    32'd5,          32'd0,         5'd10, 32'd5,        0);
    run_op(F3_DIVU,   32'h8000_0000,  32'd0,         5'd11, 32'hFFFF_FFFF, 0);
    run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 0);
    run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'd0,        0);
    run_op(F3_MUL,    32'd12345,      32'd678,       5'd14, 32'd8369910,  1);
    run_op(F3_MULHU,  32'h1234_5678,  32'h9ABC_DEF0, 5'd0,  32'h0B00_EA4E, 0);

    // Reset ten cycles into a multiply: abandoned, no done afterwards
    @(negedge clk);
    start = 1'b1; funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd15;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_out", rd_out, 0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", saw_done, 0);
    run_op(F3_DIVU, 32'd9, 32'd3, 5'd20, 32'd3, 0);

    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(rf, ra, rb, 5'($urandom_range(0, 31)), ref_op(rf, ra, rb), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
